// File: rtl/mips_pkg.sv
// Shared register-file constants for the MIPS datapath.
// Also carries a width helper used by the writeback arbiter.
package mips_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // Index width for an n-entry selector; never collapses to zero bits.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: the first set request at or above ptr
// wins, with wrap-around. This module holds no state.
module rr_arbiter
  import mips_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      // An extra bit holds ptr+k before the modulo-N wrap.
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      cand = sum[PW-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port among NREQ writeback sources
// and keeps a busy scoreboard so issue logic can stall on RAW hazards.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [AW-1:0]        write_add,
  output logic [DW-1:0]        write_dat,
  output logic                 regwrite,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_addr,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy
);

  localparam int PW = ptr_width(NREQ);

  logic [AW-1:0]       addr_arr [NREQ];
  logic [DW-1:0]       data_arr [NREQ];

  logic [PW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [AW-1:0]       write_add_reg, write_add_next;
  logic [DW-1:0]       write_dat_reg, write_dat_next;
  logic                regwrite_reg, regwrite_next;
  logic [NUM_REGS-1:0] busy_reg, busy_next;

  logic [NREQ-1:0]     grant;
  logic [PW-1:0]       win_idx;
  logic                win_any;
  logic                transfer;
  logic [AW-1:0]       win_addr;
  logic [DW-1:0]       win_data;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = req_addr[gi*AW +: AW];
    assign data_arr[gi] = req_data[gi*DW +: DW];
  end

  // Grant depends only on valid bits and the pointer, never on addr/data.
  rr_arbiter #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign req_ready = grant;
  assign transfer  = win_any;
  assign win_addr  = addr_arr[win_idx];
  assign win_data  = data_arr[win_idx];

  always_comb begin
    rr_ptr_next    = rr_ptr_reg;
    write_add_next = write_add_reg;
    write_dat_next = write_dat_reg;
    regwrite_next  = 1'b0;
    if (transfer) begin
      rr_ptr_next    = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
      write_add_next = win_addr;
      write_dat_next = win_data;
      regwrite_next  = (win_addr != '0);
    end
  end

  // Clear before set so a same-edge issue to the same register keeps it busy:
  // the issuing instruction is the newer producer.
  always_comb begin
    busy_next = busy_reg;
    if (transfer && (win_addr != '0)) begin
      busy_next[win_addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != '0)) begin
      busy_next[issue_addr] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
    busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg    <= '0;
      write_add_reg <= '0;
      write_dat_reg <= '0;
      regwrite_reg  <= 1'b0;
      busy_reg      <= '0;
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      write_add_reg <= write_add_next;
      write_dat_reg <= write_dat_next;
      regwrite_reg  <= regwrite_next;
      busy_reg      <= busy_next;
    end
  end

  assign write_add = write_add_reg;
  assign write_dat = write_dat_reg;
  assign regwrite  = regwrite_reg;
  assign busy      = busy_reg;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32×32 register file between several writeback sources (ALU, load unit, link/JAL path) using round-robin arbitration. Keeps a scoreboard of registers with an outstanding producer so that issue logic can stall on read-after-write hazards. Sits between the execute/memory stages and the register file's `write_add` / `write_dat` / `regwrite` inputs.

## Interface
Parameters:
- `NREQ`, 3: number of writeback requesters (2..8).
- `AW`, 5: register address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  requester i has a write pending.
- `req_addr`  in  NREQ*AW  destination of requester i, slice [i*AW +: AW].
- `req_data`  in  NREQ*DW  data of requester i, slice [i*DW +: DW].
- `req_ready`  out  NREQ  one-hot grant; a transfer occurs when valid & ready.
- `write_add`  out  AW  register-file write address (registered).
- `write_dat`  out  DW  register-file write data (registered).
- `regwrite`  out  1  register-file write enable, one-cycle pulse per write.
- `issue_valid`  in  1  issue stage dispatched an instruction with a destination.
- `issue_addr`  in  AW  that destination.
- `flush`  in  1  synchronous pipeline flush.
- `busy`  out  32  scoreboard; bit r set means register r has an outstanding producer.

## Operation
- Arbitration:
  - Round-robin pointer `rr_ptr` (0..NREQ-1).
  - The winner is the first requester with `req_valid` set, searching from `rr_ptr` upward with wrap-around.
  - `req_ready` is combinational: exactly the winner's bit is set, or all zero if there are no requests.
  - `req_ready` must not depend on `req_data` or `req_addr`.
  - On a transfer, `rr_ptr` becomes winner+1 mod NREQ; otherwise it holds.
- Write stage:
  - A transfer captures the winner's addr/data into `write_add`/`write_dat`.
  - `regwrite` is 1 in the next cycle if addr≠0.
  - A transfer to register 0 is accepted (ready asserted) but produces `regwrite`=0. Register 0 is never written.
  - Without a transfer, `regwrite`=0 and `write_add`/`write_dat` hold their previous values.
- Scoreboard (one bit per register):
  - Set: `issue_valid` with `issue_addr`≠0 sets bit `issue_addr`.
  - Clear: a transfer with addr≠0 clears bit addr in the same edge it is captured.
  - Simultaneous set and clear of the same bit: set wins, because the issuing instruction is the newer producer.
  - Bit 0 is constantly 0.
  - `flush`=1 clears all bits, and an `issue_valid` in the same cycle is ignored.
  - `flush` does not affect arbitration or the write stage; in-flight writebacks still complete.
- A write to a register whose busy bit is already 0 is legal and still drives `regwrite`.

## Timing
- Reset values: `write_add`=0, `write_dat`=0, `regwrite`=0, `busy`=0, `rr_ptr`=0. `req_ready` follows from `rr_ptr`=0, i.e. the lowest-index valid requester.
- Reset is asynchronous and applies mid-operation. A transfer in the cycle where `rst_n` falls is lost; requesters must re-present after reset.
- Latency from accepted request to `regwrite` high is 1 cycle. Register-file contents update on the edge after that, so total latency is 2 edges.
- Throughput is one write per cycle. Back-to-back grants produce back-to-back `regwrite` pulses.
- `busy` is registered. A bit cleared by a transfer at edge k reads 0 after edge k, one cycle before the register file holds the data. Issue logic must also forward from `write_add`/`write_dat` while `regwrite`=1; that forwarding is outside this block.
- A requester holds valid/addr/data stable until granted. The arbiter does not require this for correctness of the grant, but starvation bounds assume it.
- Fairness: a continuously valid requester is granted within NREQ cycles.

## Structure
- Shared package `mips_pkg`: `REG_AW`=5, `REG_DW`=32, `NUM_REGS`=32, `REG_ZERO`=0.
- One sub-module, `rr_arbiter`, parameterised by N:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and winner index.
  - Purely combinational.
  - Pointer update stays in `regfile_wb_arbiter`.
- Remaining logic (write-stage register, scoreboard, flush) lives in `regfile_wb_arbiter`. The complete block is about 150–250 lines.

## Test plan
- Reset check: hold `rst_n`=0 with all inputs random, then release.
  - While in reset: `regwrite`=0, `busy`=0, `write_add`=0, `write_dat`=0.
  - After release: the first grant goes to req 0 if valid.
- Single write: only req1 valid, addr=5, data=0xDEADBEEF.
  - `req_ready`=3'b010 in the same cycle.
  - Next cycle: `regwrite`=1, `write_add`=5, `write_dat`=0xDEADBEEF.
  - The following cycle: `regwrite`=0.
- Round-robin: all three valid continuously with addrs 1/2/3.
  - Grant order is 0,1,2,0,1,2.
  - `regwrite` is high for 6 consecutive cycles with `write_add` 1,2,3,1,2,3.
- Register 0: req0 valid with addr=0, data=0x12345678.
  - `req_ready[0]`=1.
  - Next cycle: `regwrite`=0 and `busy[0]`=0.
- Scoreboard race:
  - Issue addr=7: `busy[7]`=1 next cycle.
  - Later, in the same cycle, req2 writes addr=7 and issue addr=7 again: `busy[7]` stays 1 and `regwrite`=1 for addr 7.
  - A subsequent write to 7 with no issue clears `busy[7]`.
- Flush and mid-op reset:
  - Set `busy` bits 3,4,9, then `flush` together with issue addr=10: `busy`=0 next cycle.
  - Assert `rst_n`=0 asynchronously while req0 is valid: `regwrite` drops immediately and `busy`=0.
